// File: rtl/reg_arb_pkg.sv
// Shared definitions for the register-bank write-port arbiter.
// Latency: n/a (types, constants and a pointer helper only).
// Backpressure: n/a.
package reg_arb_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    localparam int DEF_NUM_REQ  = 3;
    localparam int DEF_NUM_REGS = 8;
    localparam int DEF_ADDR_W   = 3;
    localparam int DEF_DATA_W   = 24;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_GRANT = ST_GRANT
    } state_t;

    // Round-robin successor: one past the winner, wrapping at n-1.
    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_picker.sv
// Round-robin picker: first set bit of the eligible mask at or above ptr, with wrap.
// Latency: combinational.
// Backpressure: none; the caller masks requesters that cannot take a grant.
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win_oh,
    output logic [IDX_W-1:0]   win_idx,
    output logic               win_vld
);

    always_comb begin
        int idx;
        win_oh  = '0;
        win_idx = '0;
        win_vld = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'({1'b0, ptr}) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!win_vld && eligible[idx]) begin
                win_vld     = 1'b1;
                win_oh[idx] = 1'b1;
                win_idx     = idx[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the shared register-bank write port; drives one-hot load strobe and data.
// Latency: req sampled at edge N -> grant/load_en/wr_data valid during cycle N+1.
// Backpressure: requesters hold req until a one-cycle grant; the granted one is masked for a cycle.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        err,
    output logic [NUM_REGS-1:0]       load_en,
    output logic [DATA_W-1:0]         wr_data,
    output logic                      busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  win_oh;
    logic [IDX_W-1:0]    win_idx;
    logic                win_vld;
    logic [ADDR_W-1:0]   addr_sel;
    logic [DATA_W-1:0]   data_sel;
    logic                addr_ok;
    logic [NUM_REQ-1:0]  grant_d, err_d;
    logic [NUM_REGS-1:0] load_en_d;
    logic [DATA_W-1:0]   wr_data_d;
    logic                busy_d;

    // A requester granted this cycle still shows req; it drops it next cycle.
    assign eligible = req & ~grant;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .eligible (eligible),
        .ptr      (rr_ptr_q),
        .win_oh   (win_oh),
        .win_idx  (win_idx),
        .win_vld  (win_vld)
    );

    always_comb begin
        addr_sel = '0;
        data_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                addr_sel = req_addr[i*ADDR_W +: ADDR_W];
                data_sel = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign addr_ok = (32'(addr_sel) < 32'(NUM_REGS));

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = '0;
        err_d     = '0;
        load_en_d = '0;
        wr_data_d = wr_data;
        busy_d    = |eligible;

        case (state_q)
            S_IDLE:  state_d = win_vld ? S_GRANT : S_IDLE;
            S_GRANT: state_d = win_vld ? S_GRANT : S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (win_vld) begin
            grant_d  = win_oh;
            rr_ptr_d = IDX_W'(rr_next(int'({1'b0, win_idx}), NUM_REQ));
            if (addr_ok) begin
                wr_data_d = data_sel;
                for (int r = 0; r < NUM_REGS; r++) begin
                    load_en_d[r] = (32'(addr_sel) == 32'(r));
                end
            end else begin
                // Out-of-range target: still retire the request, flag it, write nothing.
                err_d = win_oh;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            grant    <= '0;
            err      <= '0;
            load_en  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant    <= grant_d;
            err      <= err_d;
            load_en  <= load_en_d;
            wr_data  <= wr_data_d;
            busy     <= busy_d;
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter (3 requesters, 6 registers so address 7 is out of range).
// Expected values are hand-derived constants plus a small register-bank model.
module tb_reg_write_arbiter;

    localparam int NUM_REQ  = 3;
    localparam int NUM_REGS = 6;
    localparam int ADDR_W   = 3;
    localparam int DATA_W   = 24;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        err;
    logic [NUM_REGS-1:0]       load_en;
    logic [DATA_W-1:0]         wr_data;
    logic                      busy;

    logic [DATA_W-1:0] bank [NUM_REGS];
    int checks   = 0;
    int failures = 0;
    int stray    = 0;

    reg_write_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .grant    (grant),
        .err      (err),
        .load_en  (load_en),
        .wr_data  (wr_data),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one edge, then sample; the bank model captures any strobe seen.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (load_en[r]) bank[r] = wr_data;
        end
    endtask

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    initial begin
        for (int r = 0; r < NUM_REGS; r++) bank[r] = '0;
        rst_n = 1'b1;
        req   = 3'b111;
        req_addr = '0;
        req_data = '0;
        set_req(0, 3'd0, 24'h111111);
        set_req(1, 3'd1, 24'h222222);
        set_req(2, 3'd2, 24'h333333);
        #1 rst_n = 1'b0;

        // Reset with all requests up
        tick();
        tick();
        chk("rst_grant",   32'(grant),   32'h0);
        chk("rst_err",     32'(err),     32'h0);
        chk("rst_load_en", 32'(load_en), 32'h0);
        chk("rst_wr_data", 32'(wr_data), 32'h0);
        chk("rst_busy",    32'(busy),    32'h0);

        rst_n = 1'b1;
        tick();
        chk("first_grant",   32'(grant),   32'h1);
        chk("first_load_en", 32'(load_en), 32'h01);
        chk("first_wr_data", 32'(wr_data), 32'h111111);
        req = 3'b000;
        tick();
        chk("first_pulse_end", 32'(grant), 32'h0);
        chk("idle_load_en",    32'(load_en), 32'h0);
        req = 3'b011;
        tick();
        chk("ptr_after_first", 32'(grant), 32'h2);
        req = 3'b000;
        tick();

        // Single request, ptr now 2
        set_req(1, 3'd5, 24'hABCDEF);
        req = 3'b010;
        tick();
        chk("single_grant",   32'(grant),   32'h2);
        chk("single_load_en", 32'(load_en), 32'h20);
        chk("single_wr_data", 32'(wr_data), 32'hABCDEF);
        chk("single_err",     32'(err),     32'h0);
        chk("single_busy",    32'(busy),    32'h1);
        req = 3'b000;
        tick();
        chk("single_pulse_end", 32'(grant),   32'h0);
        chk("single_ld_end",    32'(load_en), 32'h0);
        chk("single_wr_hold",   32'(wr_data), 32'hABCDEF);
        chk("single_busy_end",  32'(busy),    32'h0);

        // Out-of-range address, ptr 2 -> 0 afterwards
        set_req(2, 3'd7, 24'h777777);
        req = 3'b100;
        tick();
        chk("bad_grant",   32'(grant),   32'h4);
        chk("bad_err",     32'(err),     32'h4);
        chk("bad_load_en", 32'(load_en), 32'h0);
        chk("bad_wr_hold", 32'(wr_data), 32'hABCDEF);
        req = 3'b000;
        tick();
        chk("bad_err_end", 32'(err), 32'h0);

        // Round-robin with granted requester dropping and others re-raising
        set_req(0, 3'd0, 24'h000A00);
        set_req(1, 3'd1, 24'h000B01);
        set_req(2, 3'd2, 24'h000C02);
        req = 3'b111;
        begin
            logic [NUM_REQ-1:0]  exp_g [4];
            logic [NUM_REGS-1:0] exp_l [4];
            exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
            exp_l[0] = 6'h01;  exp_l[1] = 6'h02;  exp_l[2] = 6'h04;  exp_l[3] = 6'h01;
            for (int c = 0; c < 4; c++) begin
                tick();
                chk($sformatf("rr_grant%0d", c),   32'(grant),   32'(exp_g[c]));
                chk($sformatf("rr_load_en%0d", c), 32'(load_en), 32'(exp_l[c]));
                req = 3'b111 & ~grant;
            end
        end
        req = 3'b000;
        tick();
        chk("rr_idle", 32'(grant), 32'h0);

        // Move ptr from 1 to 2, then collide req0/req2 on register 3
        req = 3'b010;
        tick();
        req = 3'b000;
        tick();
        set_req(0, 3'd3, 24'h000111);
        set_req(2, 3'd3, 24'h000222);
        req = 3'b101;
        tick();
        chk("col_first_grant", 32'(grant),   32'h4);
        chk("col_first_data",  32'(wr_data), 32'h000222);
        chk("col_first_load",  32'(load_en), 32'h08);
        req = 3'b001;
        tick();
        chk("col_second_grant", 32'(grant),   32'h1);
        chk("col_second_data",  32'(wr_data), 32'h000111);
        req = 3'b000;
        tick();
        chk("col_final_reg3", 32'(bank[3]), 32'h000111);

        // Reset in the middle of a grant cycle (ptr 1, req2 targets reg 2)
        set_req(2, 3'd2, 24'h0C0FFE);
        req = 3'b100;
        tick();
        chk("mid_load_en", 32'(load_en), 32'h04);
        #2 rst_n = 1'b0;
        req = 3'b000;
        #1;
        chk("mid_rst_load_en", 32'(load_en), 32'h0);
        chk("mid_rst_grant",   32'(grant),   32'h0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (load_en != '0 || grant != '0) stray++;
        end
        chk("post_rst_no_pulse", 32'(stray), 32'h0);
        set_req(1, 3'd4, 24'h444444);
        set_req(2, 3'd5, 24'h555555);
        req = 3'b110;
        tick();
        chk("post_rst_grant",   32'(grant),   32'h2);
        chk("post_rst_load_en", 32'(load_en), 32'h10);
        req = 3'b000;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
